// File: rtl/alu_flag_stage.sv
// Execute stage that feeds the flag register and register file.
// Single-cycle ALU ops finish in one edge. Shift and multiply iterate in EXEC.
module alu_flag_stage #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             low_out,
  output logic             negative_out,
  output logic             zero_out,
  output logic             flag_we
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [SHW-1:0]   count_q;
  logic             dir_right_q;
  logic             rwe_q;
  logic             fwe_q;

  logic [SHW-1:0]   k_raw;
  logic [SHW-1:0]   k_mag;
  logic             k_neg;

  logic [WIDTH-1:0] alu_res;
  logic             alu_low;
  logic             alu_neg;
  logic             alu_zero;
  logic             alu_rwe;
  logic             alu_fwe;

  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] step_val;
  logic             last_step;

  // The shift amount is a signed field; its magnitude is the EXEC cycle count.
  assign k_raw = b[SHW-1:0];
  assign k_neg = k_raw[SHW-1];
  assign k_mag = k_neg ? -k_raw : k_raw;

  assign mul_sum   = opb_q[0] ? (acc_q + opa_q) : acc_q;
  assign shift_val = dir_right_q ? (opa_q >> 1) : (opa_q << 1);
  assign step_val  = (op_q == OP_MUL) ? mul_sum : shift_val;
  assign last_step = (count_q == SHW'(1));

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign result_we = done & rwe_q;
  assign flag_we   = done & fwe_q;

  always_comb begin
    alu_res  = result;
    alu_rwe  = 1'b1;
    alu_fwe  = 1'b1;
    alu_low  = 1'b0;
    alu_neg  = 1'b0;
    alu_zero = 1'b0;
    case (opcode)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_CMP:  alu_rwe = 1'b0;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_MOV: begin
        alu_res = b;
        alu_fwe = 1'b0;
      end
      OP_LSH:  alu_res = a;
      OP_MUL:  alu_res = result;
      default: begin
        alu_rwe = 1'b0;
        alu_fwe = 1'b0;
      end
    endcase
    // Subtract and compare report the relation of the operands, not the result.
    if (opcode == OP_SUB || opcode == OP_CMP) begin
      alu_low  = (a < b);
      alu_neg  = ($signed(a) < $signed(b));
      alu_zero = (a == b);
    end else begin
      alu_low  = 1'b0;
      alu_neg  = alu_res[WIDTH-1];
      alu_zero = (alu_res == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (opcode == OP_MUL || (opcode == OP_LSH && k_mag != '0)) begin
            next_state = EXEC;
          end else begin
            next_state = DONE;
          end
        end
      end
      EXEC: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      acc_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      count_q      <= '0;
      dir_right_q  <= 1'b0;
      rwe_q        <= 1'b0;
      fwe_q        <= 1'b0;
      result       <= '0;
      low_out      <= 1'b0;
      negative_out <= 1'b0;
      zero_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= opcode;
            if (next_state == EXEC) begin
              acc_q       <= '0;
              opa_q       <= a;
              opb_q       <= b;
              dir_right_q <= k_neg;
              count_q     <= (opcode == OP_MUL) ? SHW'(WIDTH) : k_mag;
              rwe_q       <= 1'b0;
              fwe_q       <= 1'b0;
            end else begin
              rwe_q <= alu_rwe;
              fwe_q <= alu_fwe;
              if (alu_rwe) begin
                result <= alu_res;
              end
              if (alu_fwe) begin
                low_out      <= alu_low;
                negative_out <= alu_neg;
                zero_out     <= alu_zero;
              end
            end
          end
        end
        EXEC: begin
          acc_q   <= mul_sum;
          opa_q   <= (op_q == OP_MUL) ? (opa_q << 1) : shift_val;
          opb_q   <= opb_q >> 1;
          count_q <= count_q - SHW'(1);
          if (last_step) begin
            result       <= step_val;
            low_out      <= 1'b0;
            negative_out <= step_val[WIDTH-1];
            zero_out     <= (step_val == '0);
            rwe_q        <= 1'b1;
            fwe_q        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: directed vectors push expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_flag_stage;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        result_we;
  logic        low_out;
  logic        negative_out;
  logic        zero_out;
  logic        flag_we;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        low;
    logic        neg;
    logic        zero;
    logic        rwe;
    logic        fwe;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_flag_stage #(.WIDTH(16), .SHW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_we    (result_we),
    .low_out      (low_out),
    .negative_out (negative_out),
    .zero_out     (zero_out),
    .flag_we      (flag_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: busy still 1, expected 0", name);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic [3:0] op,
                                input logic [15:0] av, input logic [15:0] bv,
                                input logic [15:0] er, input logic el, input logic en,
                                input logic ez, input logic erwe, input logic efwe,
                                input int elat);
    exp_t e;
    wait_idle({name, " pre"});
    e.name = name;
    e.res = er;
    e.low = el;
    e.neg = en;
    e.zero = ez;
    e.rwe = erwe;
    e.fwe = efwe;
    e.lat = elat;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    opcode = op;
    a = av;
    b = bv;
    @(negedge clk);
    // Scramble the inputs to prove the operands were captured at start.
    start = 1'b0;
    opcode = 4'd0;
    a = ~av;
    b = ~bv;
    wait_idle(name);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected done: got done=1 with result 0x%0h, expected no done", result);
        end else begin
          e = sb.pop_front();
          check_output({e.name, " result"}, 32'(result), 32'(e.res));
          check_output({e.name, " low"}, 32'(low_out), 32'(e.low));
          check_output({e.name, " negative"}, 32'(negative_out), 32'(e.neg));
          check_output({e.name, " zero"}, 32'(zero_out), 32'(e.zero));
          check_output({e.name, " result_we"}, 32'(result_we), 32'(e.rwe));
          check_output({e.name, " flag_we"}, 32'(flag_we), 32'(e.fwe));
          check_output({e.name, " latency"}, 32'(cyc - e.start_cyc + 1), 32'(e.lat));
          check_output({e.name, " busy"}, 32'(busy), 32'd1);
        end
      end else if (result_we || flag_we) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL strobe without done: got we=%0b/%0b, expected 0/0", result_we, flag_we);
      end
    end
  end

  initial begin
    int guard;
    exp_t e;
    reset = 1'b1;
    start = 1'b0;
    opcode = 4'd0;
    a = 16'h0;
    b = 16'h0;
    repeat (2) @(negedge clk);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset result", 32'(result), 32'd0);
    check_output("reset flags", 32'({low_out, negative_out, zero_out}), 32'd0);
    check_output("reset we", 32'({result_we, flag_we}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //              name        op      a         b         result    L  N  Z  rwe fwe lat
    apply_stimulus("add wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 1, 1, 1, 1);
    apply_stimulus("sub lt",   OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1, 1, 0, 1, 1, 1);
    apply_stimulus("cmp",      OP_CMP, 16'h0003, 16'h8000, 16'hFFFE, 1, 0, 0, 0, 1, 1);
    apply_stimulus("and",      OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 1, 1, 1);
    apply_stimulus("or",       OP_OR,  16'h8000, 16'h0001, 16'h8001, 0, 1, 0, 1, 1, 1);
    apply_stimulus("xor",      OP_XOR, 16'h1234, 16'h1234, 16'h0000, 0, 0, 1, 1, 1, 1);
    apply_stimulus("mov",      OP_MOV, 16'h5555, 16'h8001, 16'h8001, 0, 0, 1, 1, 0, 1);
    apply_stimulus("illegal",  4'd9,   16'h1111, 16'h2222, 16'h8001, 0, 0, 1, 0, 0, 1);
    apply_stimulus("mul",      OP_MUL, 16'h0123, 16'h0010, 16'h1230, 0, 0, 0, 1, 1, 17);
    apply_stimulus("mul ovf",  OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 0, 1, 1, 17);
    apply_stimulus("lsh -1",   OP_LSH, 16'h8001, 16'h001F, 16'h4000, 0, 0, 0, 1, 1, 2);
    apply_stimulus("lsh +15",  OP_LSH, 16'h0001, 16'h000F, 16'h8000, 0, 1, 0, 1, 1, 16);
    apply_stimulus("lsh 0",    OP_LSH, 16'h00A5, 16'h0020, 16'h00A5, 0, 0, 0, 1, 1, 1);
    apply_stimulus("lsh -16",  OP_LSH, 16'hFFFF, 16'h0010, 16'h0000, 0, 0, 1, 1, 1, 17);
    apply_stimulus("sub sgn",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 1, 1, 1);
    apply_stimulus("cmp eq",   OP_CMP, 16'h1234, 16'h1234, 16'h7FFF, 0, 0, 1, 0, 1, 1);

    // Start held high with ADD operands during a MUL: only the MUL completes.
    wait_idle("drop pre");
    e.name = "mul drop";
    e.res = 16'h000F;
    e.low = 1'b0;
    e.neg = 1'b0;
    e.zero = 1'b0;
    e.rwe = 1'b1;
    e.fwe = 1'b1;
    e.lat = 17;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    opcode = OP_MUL;
    a = 16'h0003;
    b = 16'h0005;
    @(negedge clk);
    guard = 0;
    while (!done && guard < 100) begin
      start = 1'b1;
      opcode = OP_ADD;
      a = 16'h0001;
      b = 16'h0001;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check_output("drop done seen", 32'(done), 32'd1);
    apply_stimulus("add after", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 1, 1, 1);

    // Asynchronous reset mid-multiply aborts with no done pulse.
    apply_stimulus("sub pre rst", OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1, 1, 0, 1, 1, 1);
    wait_idle("rst pre");
    start = 1'b1;
    opcode = OP_MUL;
    a = 16'h0123;
    b = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort done", 32'(done), 32'd0);
    check_output("abort result", 32'(result), 32'd0);
    check_output("abort flags", 32'({low_out, negative_out, zero_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus("add post rst", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 1, 1);

    repeat (3) @(negedge clk);
    check_output("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Execute stage that sits directly upstream of the processor flag register.
- Performs arithmetic, logic, shift and multiply on two operands.
- Drives the Low/Negative/Zero values and the write-enable that the flag register latches, plus a result and write strobe for the register file.
- Single-cycle ops complete in one clock; shift and multiply are iterative, under a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 8..32.
SHW, 5, width of the signed shift-amount field b[SHW-1:0]; must equal clog2(WIDTH)+1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  request; sampled only in IDLE
opcode  in  4  operation select (encoding below)
a  in  WIDTH  operand A (destination/left operand)
b  in  WIDTH  operand B (source/right operand, or shift amount)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
result  out  WIDTH  registered result; held until the next completion
result_we  out  1  register-file write strobe; asserted only together with done
low_out  out  1  Low flag value for the flag register
negative_out  out  1  Negative flag value
zero_out  out  1  Zero flag value
flag_we  out  1  flag-register enable; asserted only together with done

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports are named clk and reset.
- Reset: state=IDLE; busy, done, result_we and flag_we are 0; result=0; all flag outputs are 0. Reset asserted mid-operation aborts the operation with no done pulse.
- Opcodes: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 MOV (result=b), 7 LSH, 8 MUL. Codes 9-15 are illegal.
- Capture: on the edge where start=1 in IDLE, opcode, a and b are registered. Later changes on the inputs are ignored. start while busy=1 is dropped (not queued).
- States: IDLE -> DONE for ADD/SUB/CMP/AND/OR/XOR/MOV/illegal. IDLE -> EXEC for LSH with nonzero amount, and for MUL. EXEC -> DONE when the iteration count is exhausted. DONE -> IDLE unconditionally.
- done, result_we and flag_we are high only in DONE, so back-to-back single-cycle ops accept start every 2nd cycle.
- Latency is counted in edges from the start-sampling edge to the edge that raises done:
  - single-cycle ops: 1
  - LSH: |k|+1, where k is the signed value of b[SHW-1:0]; k=0 gives 1
  - MUL: WIDTH+1 (17 at default)
- LSH: k>0 shifts left one bit per EXEC cycle; k<0 shifts right logically (zero fill). |k|>=WIDTH yields 0.
- MUL: shift-add, one multiplier bit per cycle; result = low WIDTH bits of the unsigned product; overflow is discarded.
- ADD/SUB/AND/OR/XOR/MOV wrap modulo 2^WIDTH.
- Flags for SUB and CMP:
  - low_out = (a < b) unsigned
  - negative_out = (a < b) signed
  - zero_out = (a == b)
- Flags for all other legal ops: low_out=0, negative_out=result[WIDTH-1], zero_out=(result==0).
- result_we: 1 for all legal ops except CMP. For CMP, result keeps its previous value.
- flag_we: 1 for all legal ops except MOV. Flag outputs hold their previous values when flag_we=0.
- Illegal opcode: enters DONE with done=1 and both result_we and flag_we low. result and flags are unchanged.
- done never coincides with busy=0; busy is high during DONE.

Test Plan:
- ADD a=0xFFFF b=0x0001 -> done at edge 1; result=0x0000; zero=1, negative=0, low=0; result_we=1, flag_we=1.
- CMP a=0x0003 b=0x8000 -> low=1, negative=0, zero=0; flag_we=1, result_we=0; result unchanged.
- MUL a=0x0123 b=0x0010 -> busy for edges 1-17; done at edge 17; result=0x1230, zero=0, negative=0. Then MUL 0xFFFF*0xFFFF -> result=0x0001.
- LSH a=0x8001 b=0x001F (k=-1) -> done at edge 2, result=0x4000. Then LSH a=0x0001 b=0x000F (k=15) -> done at edge 16, result=0x8000, negative=1.
- Start pulsed every cycle during a MUL with ADD operands -> ADD is dropped; exactly one done, carrying the MUL result. An ADD started the cycle after done completes normally.
- Reset asserted at edge 8 of a MUL, asynchronously mid-cycle -> busy, done and flags drop to 0 immediately; no done pulse; a new ADD after reset is released completes with latency 1.
